// File: rtl/shift_seq_pkg.sv
// Shared encodings and widths for the sequential shift controller.
// Shifts are performed as a sequence of power-of-two steps.
package shift_seq_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Index of the highest set bit; returns 0 for an all-zero input.
  function automatic logic [2:0] msb_index(input logic [SHAMT_W-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (v[i]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step: shifts acc by 2^k according to op and
// reports the last bit shifted out.
module shift_step
  import shift_seq_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] acc,
  input  logic [2:0]        k,
  output logic [DATA_W-1:0] acc_o,
  output logic              c_o
);

  logic [4:0] amt;
  logic [4:0] idx_l;
  logic [4:0] idx_r;

  always_comb begin
    amt   = 5'd1 << k;
    // 32 - amt modulo 32; amt never reaches 32 so no wrap ambiguity.
    idx_l = ~amt + 5'd1;
    idx_r = amt - 5'd1;
    acc_o = acc;
    c_o   = acc[idx_r];
    case (op)
      OP_SLL: begin
        acc_o = acc << amt;
        c_o   = acc[idx_l];
      end
      OP_SRL: acc_o = acc >> amt;
      OP_SRA: acc_o = $unsigned($signed(acc) >>> amt);
      OP_ROR: acc_o = (acc >> amt) | (acc << (6'd32 - {1'b0, amt}));
      default: acc_o = acc;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequential shifter controller: one power-of-two step per SHIFT cycle,
// result held in DONE until the consumer takes it.
module shift_seq_ctrl
  import shift_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [DATA_W-1:0]   in_t,
  input  logic [SHAMT_W-1:0]  in_shamt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_y,
  output logic                out_c,
  output logic                out_n,
  output logic                out_z,
  output logic                busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready
  // are both high; in_ready never depends on in_valid.

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;
  logic [1:0]           op_q, op_d;
  logic                 c_q, c_d;

  logic [2:0]           k;
  logic [DATA_W-1:0]    step_acc;
  logic                 step_c;
  logic [SHAMT_W-1:0]   rem_clr;

  shift_step u_step (
    .op    (op_q),
    .acc   (acc_q),
    .k     (k),
    .acc_o (step_acc),
    .c_o   (step_c)
  );

  always_comb begin
    k       = msb_index(rem_q);
    rem_clr = rem_q & ~(5'd1 << k);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          acc_d   = in_t;
          rem_d   = in_shamt;
          op_d    = in_op;
          c_d     = 1'b0;
          state_d = (in_shamt != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        acc_d = step_acc;
        c_d   = step_c;
        rem_d = rem_clr;
        if (rem_clr == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush aborts only the control flow; datapath keeps whatever it holds.
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= OP_SLL;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !flush;
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    out_y     = acc_q;
    out_c     = c_q;
    out_n     = acc_q[DATA_W-1];
    out_z     = (acc_q == '0);
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: a driver pushes expected results,
// a monitor pops and compares whenever out_valid first rises.
module tb_shift_seq_ctrl;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_t;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        out_c;
  logic        out_n;
  logic        out_z;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_edge = 0;

  logic [34:0] exp_q[$];
  int          lat_q[$];

  shift_seq_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_t      (in_t),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_c     (out_c),
    .out_n     (out_n),
    .out_z     (out_z),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] op, input logic [31:0] t, input logic [4:0] sh,
                      input logic [31:0] ey, input logic ec, input logic en, input logic ez,
                      input int lat, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", {63'd0, in_ready}, 64'd1);
    if (push) begin
      exp_q.push_back({ey, ec, en, ez});
      lat_q.push_back(lat);
    end
    in_op    = op;
    in_t     = t;
    in_shamt = sh;
    in_valid = 1'b1;
    acc_edge = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || out_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit seen;
    logic [34:0] e;
    int lat;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        seen = 1'b0;
      end else begin
        if (out_valid && !seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 64'd1, 64'd0);
          end else begin
            e   = exp_q.pop_front();
            lat = lat_q.pop_front();
            chk("out_y", {32'd0, out_y}, {32'd0, e[34:3]});
            chk("out_c", {63'd0, out_c}, {63'd0, e[2]});
            chk("out_n", {63'd0, out_n}, {63'd0, e[1]});
            chk("out_z", {63'd0, out_z}, {63'd0, e[0]});
            chk("latency", 64'(cyc - acc_edge + 1), 64'(lat));
          end
        end
        if (!out_valid || out_ready) seen = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_t      = 32'd0;
    in_shamt  = 5'd0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_y",     {32'd0, out_y}, 64'd0);
    chk("rst_out_c",     {63'd0, out_c}, 64'd0);
    chk("rst_out_n",     {63'd0, out_n}, 64'd0);
    chk("rst_out_z",     {63'd0, out_z}, 64'd1);
    chk("rst_busy",      {63'd0, busy}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    flush = 1'b1;
    #1;
    chk("rst_in_ready_flush", {63'd0, in_ready}, 64'd0);
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors: op, T, shamt, expected y, C, N, Z, latency
    send(2'b01, 32'h80000001, 5'd31, 32'h00000001, 0, 0, 0, 6, 1); wait_idle();
    send(2'b10, 32'h80000000, 5'd4,  32'hF8000000, 0, 1, 0, 2, 1); wait_idle();
    send(2'b00, 32'h00000003, 5'd31, 32'h80000000, 1, 1, 0, 6, 1); wait_idle();
    send(2'b11, 32'h00000001, 5'd1,  32'h80000000, 1, 1, 0, 2, 1); wait_idle();
    send(2'b11, 32'h00000000, 5'd0,  32'h00000000, 0, 0, 1, 1, 1); wait_idle();
    send(2'b00, 32'hFFFFFFFF, 5'd0,  32'hFFFFFFFF, 0, 1, 0, 1, 1); wait_idle();
    send(2'b10, 32'h7FFFFFF0, 5'd5,  32'h03FFFFFF, 1, 0, 0, 3, 1); wait_idle();
    send(2'b01, 32'h0000000F, 5'd4,  32'h00000000, 1, 0, 1, 2, 1); wait_idle();
    send(2'b11, 32'h12345678, 5'd8,  32'h78123456, 0, 0, 0, 2, 1); wait_idle();

    // Backpressure: hold DONE for 3 cycles, then back-to-back request
    out_ready = 1'b0;
    send(2'b00, 32'h00000001, 5'd3, 32'h00000008, 0, 0, 0, 3, 1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_out_y",     {32'd0, out_y}, 64'h8);
      chk("hold_flags",     {61'd0, out_c, out_n, out_z}, 64'd0);
      chk("hold_in_ready",  {63'd0, in_ready}, 64'd0);
      chk("hold_busy",      {63'd0, busy}, 64'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
    send(2'b11, 32'h0000000F, 5'd4, 32'hF0000000, 1, 1, 0, 2, 1); wait_idle();

    // Flush in the 2nd SHIFT cycle of SRL shamt=7
    send(2'b01, 32'hFFFFFFFF, 5'd7, 32'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy",      {63'd0, busy}, 64'd0);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    begin
      bit saw;
      saw = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (out_valid) saw = 1'b1;
      end
      chk("flush_no_valid", {63'd0, saw}, 64'd0);
    end
    send(2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 0, 1, 0, 6, 1); wait_idle();

    // Reset pulse in the 2nd SHIFT cycle of SRL shamt=7
    send(2'b01, 32'hFFFFFFFF, 5'd7, 32'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_y",     {32'd0, out_y}, 64'd0);
    chk("midrst_out_z",     {63'd0, out_z}, 64'd1);
    chk("midrst_busy",      {63'd0, busy}, 64'd0);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    begin
      bit saw;
      saw = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (out_valid) saw = 1'b1;
      end
      chk("rst_no_valid", {63'd0, saw}, 64'd0);
    end
    send(2'b01, 32'h80000001, 5'd31, 32'h00000001, 0, 0, 0, 6, 1); wait_idle();

    // Flush together with in_valid in IDLE must not accept
    in_op    = 2'b00;
    in_t     = 32'h1;
    in_shamt = 5'd1;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_idle_busy", {63'd0, busy}, 64'd0);
    repeat (4) @(negedge clk);
    chk("flush_idle_no_valid", {63'd0, out_valid}, 64'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
